// File: rtl/stage_controller.sv
// Stage sequencer for the multi-cycle core: owns stage, pc and ir, with stall, halt and misaligned-target trap.
// Define STAGE_CTRL_PERF_EN to add the cycle_count and instret_count performance counters.
module stage_controller #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [1:0]  FETCH_STAGE = 2'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] instr_in,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt_req,
   output logic [1:0]  stage,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] ir,
   output logic        halted,
   output logic        misaligned
`ifdef STAGE_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count
`endif
);

   localparam logic [1:0] WB_STAGE = FETCH_STAGE - 2'd1;

   logic bad_target;
   logic commit_edge;

   assign pc_plus4    = pc + 32'd4;
   assign bad_target  = branch_taken && (branch_target[1:0] != 2'b00);
   assign commit_edge = !halted && !stall && (stage == WB_STAGE);

   // Halt outranks stall, so a halted core ignores every control input until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage      <= FETCH_STAGE;
         pc         <= RESET_PC;
         ir         <= 32'h0000_0000;
         halted     <= 1'b0;
         misaligned <= 1'b0;
      end else if (!halted && !stall) begin
         stage <= stage + 2'd1;
         if (stage == FETCH_STAGE) begin
            ir <= instr_in;
         end
         if (stage == WB_STAGE) begin
            stage <= FETCH_STAGE;
            if (bad_target) begin
               misaligned <= 1'b1;
               halted     <= 1'b1;
            end else if (halt_req) begin
               halted <= 1'b1;
            end else if (branch_taken) begin
               pc <= branch_target;
            end else begin
               pc <= pc_plus4;
            end
         end
      end
   end

`ifdef STAGE_CTRL_PERF_EN
   // Retirement counts only instructions that complete without halting the core.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_count   <= 32'h0000_0000;
         instret_count <= 32'h0000_0000;
      end else begin
         if (!halted) begin
            cycle_count <= cycle_count + 32'd1;
         end
         if (commit_edge && !bad_target && !halt_req) begin
            instret_count <= instret_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/stage_controller.md
# stage_controller

Sequencer for the multi-cycle RISC-V core. Owns the 2-bit `stage` counter that the fetch unit decodes (instruction-memory read enabled at stage 3), the program counter, and the instruction register. It advances one stage per clock, commits the next PC at the end of each instruction, and supports stall, halt and misaligned-target trapping.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `FETCH_STAGE`, 2'd3, stage encoding that fetches; fixed by the fetch unit.

Ports:
- `clk`  input  1  single system clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `stall`  input  1  freezes `stage`, `pc` and `ir` while high.
- `instr_in`  input  32  instruction from the fetch unit, valid during stage 3.
- `branch_taken`  input  1  redirect request, sampled only in stage 2.
- `branch_target`  input  32  redirect address, sampled with `branch_taken`.
- `halt_req`  input  1  halt request (ECALL/EBREAK decode), sampled only in stage 2.
- `stage`  output  2  current stage: 3 FETCH, 0 DECODE, 1 EXECUTE, 2 WRITEBACK.
- `pc`  output  32  address of the current instruction; fetch uses `pc/4`.
- `pc_plus4`  output  32  combinational `pc + 4`, mod 2^32.
- `ir`  output  32  latched instruction for stages 0–2.
- `halted`  output  1  core stopped; sticky until reset.
- `misaligned`  output  1  halt cause: taken target with `branch_target[1:0] != 0`.

## Operation
- Stage order: 3 → 0 → 1 → 2 → 3. One transition per un-stalled clock; the counter is encoded as a wrapping 2-bit increment.
- Priority per edge: `rst` > `halted` > `stall` > normal advance.
- Stage 3: `ir <= instr_in`.
- Stage 2, end of instruction, evaluated in this order:
  - `branch_taken` and `branch_target[1:0] != 0`: `misaligned <= 1`, `halted <= 1`, and `pc` is unchanged. This applies regardless of `halt_req`.
  - Otherwise `halt_req`: `halted <= 1`. `pc` is unchanged and points at the halting instruction.
  - Otherwise `branch_taken`: `pc <= branch_target`.
  - Otherwise `pc <= pc + 4`, wrapping 32'hFFFF_FFFC → 32'h0000_0000.
  - In all cases `stage <= 3`.
- While halted: `stage` holds 3, and `pc`, `ir` and the flags are frozen. `branch_taken`, `halt_req` and `stall` are ignored.
- `branch_taken` and `halt_req` in stages 3, 0 and 1 are ignored.
- `stall` during stage 2 delays the PC commit. Inputs are re-sampled on the first un-stalled edge.

## Timing
- Reset values: `stage = 3`, `pc = RESET_PC`, `ir = 0`, `halted = 0`, `misaligned = 0`.
- Asserting `rst` clears all state immediately, including mid-instruction or while halted.
- After `rst` deasserts, the first rising edge captures `ir` from `RESET_PC` and moves to stage 0.
- Each instruction takes exactly 4 cycles with no stall. The new `pc` is visible in the cycle after the stage 2 edge, together with `stage = 3`.
- Each stall cycle adds exactly one cycle. No combinational path runs from inputs to `stage`, `pc` or `ir`; `pc_plus4` depends only on `pc`.

## Configuration
- `STAGE_CTRL_PERF_EN` defined:
  - Adds outputs `cycle_count[31:0]`, which increments on every edge while not halted (stalls included).
  - Adds `instret_count[31:0]`, which increments on each un-stalled stage 2 edge that does not halt.
  - Both counters reset to 0 and wrap mod 2^32.
- `STAGE_CTRL_PERF_EN` undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- Reset, then run with `RESET_PC=0`, no stall or branch, for 12 cycles → `stage` sequence 3,0,1,2 repeating; `pc` = 0, 4, 8; `ir` equals the word at each address.
- Assert `branch_taken=1` with `branch_target=32'h40` in stage 2 at `pc=8` → next cycle `pc=32'h40`, `stage=3`.
- Assert `branch_taken=1` with `branch_target=32'h42` in stage 2 → `misaligned=1`, `halted=1`, `pc` stays 8; later `halt_req` and `branch_taken` have no effect.
- Assert `stall` for 3 cycles in stage 1, then drop it → `stage` holds 1 for 3 cycles and the instruction completes in 7 cycles; with `STAGE_CTRL_PERF_EN`, `cycle_count` includes the stalls and `instret_count` increments by 1.
- Run a normal stage 2 commit at `pc=32'hFFFF_FFFC` → `pc=0`; separately, assert `rst` during stage 1 → outputs return to reset values immediately, asynchronously.
- Assert `halt_req` at `pc=32'h10` → `halted=1`, `misaligned=0`, `pc=32'h10`, `stage` stays 3 until `rst`.
